// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM states,
// forwarding-mux encodings, start-up length and memory timeout.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2,
        ERROR   = 2'd3
    } state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int         INIT_CYCLES = 2;
    localparam logic [7:0] MEM_TIMEOUT = 8'd255;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic inc);
        if (inc && value != 16'hFFFF) return value + 16'd1;
        return value;
    endfunction

endpackage

// File: rtl/forward_select.sv
// Operand forwarding select for one ALU input; the Memory stage wins over
// Writeback because it holds the younger result.
module forward_select
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_w_i,
    output logic [1:0] fwd_o
);

    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && rd_m_i != 5'd0 && rd_m_i == rs_e_i)
            fwd_o = FWD_M;
        else if (reg_write_w_i && rd_w_i != 5'd0 && rd_w_i == rs_e_i)
            fwd_o = FWD_W;
    end

endmodule

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard controller: start-up sequencing, forwarding,
// load-use / branch / data-memory hazards, timeout detection and perf counters.
module hazard_controller
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  RS1_D,
    input  logic [4:0]  RS2_D,
    input  logic [4:0]  RS1_E,
    input  logic [4:0]  RS2_E,
    input  logic [4:0]  RD_E,
    input  logic        ResultSrcE,
    input  logic        PCSrcE,
    input  logic [4:0]  RD_M,
    input  logic        RegWriteM,
    input  logic        MemAccessM,
    input  logic        dmem_ready,
    input  logic [4:0]  RD_W,
    input  logic        RegWriteW,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        pipe_ready,
    output logic        mem_timeout,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [1:0] INIT_LAST = 2'(INIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  init_cnt_q, init_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_count_q, flush_count_q;
    logic        stall_inc, flush_inc, mem_busy, lw_stall;
    logic [1:0]  fwd_a, fwd_b;

    forward_select u_fwd_a (
        .rs_e_i        (RS1_E),
        .rd_m_i        (RD_M),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RD_W),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_a)
    );

    forward_select u_fwd_b (
        .rs_e_i        (RS2_E),
        .rd_m_i        (RD_M),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RD_W),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_b)
    );

    assign lw_stall = ResultSrcE && RD_E != 5'd0 && (RD_E == RS1_D || RD_E == RS2_D);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, exactly as the hardware does.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= INIT;
            init_cnt_q    <= 2'd0;
            wait_cnt_q    <= 8'd0;
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= sat_inc16(stall_count_q, stall_inc);
            flush_count_q <= sat_inc16(flush_count_q, flush_inc);
        end
    end

    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = wait_cnt_q;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        pipe_ready = 1'b0;
        mem_busy   = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        case (state_q)
            INIT: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                if (init_cnt_q == INIT_LAST) state_d = RUN;
                else                         init_cnt_d = init_cnt_q + 2'd1;
            end

            RUN, MEMWAIT: begin
                pipe_ready = 1'b1;
                // MemAccessM is held by StallM while waiting, so only ready matters then.
                mem_busy = (state_q == RUN) ? (MemAccessM && !dmem_ready) : !dmem_ready;
                if (mem_busy) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                    if (state_q == RUN) begin
                        state_d    = MEMWAIT;
                        wait_cnt_d = 8'd1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                        if (wait_cnt_d == MEM_TIMEOUT) state_d = ERROR;
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                    if (PCSrcE) begin
                        FlushD    = 1'b1;
                        FlushE    = 1'b1;
                        flush_inc = 1'b1;
                    end else if (lw_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                stall_inc = StallD;
            end

            ERROR: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end

            default: state_d = INIT;
        endcase
    end

    assign ForwardAE   = (state_q == INIT) ? FWD_RF : fwd_a;
    assign ForwardBE   = (state_q == INIT) ? FWD_RF : fwd_b;
    assign mem_timeout = (state_q == ERROR);
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule
